image_stream_source: RTL and testbench

//  Transmit side of the pixel-buffer interface: streams a stored WIDTH x DEPTH 8-bit frame
//  as image_input/enable beats, then raises enable_process to drain the buffer.

---
 rtl/image_stream_source.sv | 160 ++++++++++++++++
 tb/tb_image_stream_source.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/image_stream_source.sv
// Streams a stored WIDTH x DEPTH 8-bit frame as enable/pix_out beats, then holds enable_process
// for a fixed drain window. Define IMG_SRC_PATTERN_EN to replace the frame RAM with a (row+col) ramp.
module image_stream_source #(
  parameter int unsigned WIDTH  = 410,
  parameter int unsigned DEPTH  = 361,
  parameter int unsigned ADDR_W = 18
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              load_we_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [7:0]        load_data_i,
  output logic [7:0]        pix_out_o,
  output logic              enable_o,
  output logic              enable_process_o,
  input  logic              finish_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned NumPix = WIDTH * DEPTH;
  localparam logic [ADDR_W:0]   NumPixA   = (ADDR_W + 1)'(NumPix);
  localparam logic [ADDR_W-1:0] DrainLast = ADDR_W'(NumPix - 1);
  localparam logic [8:0]        LastRow   = 9'(WIDTH - 1);
  localparam logic [8:0]        LastCol   = 9'(DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StSend, StGap, StProc, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W:0]   addr_q;
  logic [ADDR_W-1:0] drain_q;
  logic [8:0]        row_q, col_q;
  logic [7:0]        pix_q;
  logic              enable_q, enable_process_q, busy_q, done_q, err_q, fin_q;
  logic [7:0]        pix_src;

`ifdef IMG_SRC_PATTERN_EN
  assign pix_src = row_q[7:0] + col_q[7:0];

  logic unused_load;
  assign unused_load = ^{load_we_i, load_addr_i, load_data_i, addr_q};
`else
  logic [7:0]        mem [2**ADDR_W];
  logic [7:0]        rd_q, pipe_q;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  // Address 0 is read on the start edge; addr_q then holds the next address to issue.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = addr_q[ADDR_W-1:0];
    if (state_q == StIdle) begin
      rd_en   = start_i;
      rd_addr = '0;
    end else if ((state_q == StFetch || state_q == StSend) && addr_q < NumPixA) begin
      rd_en = 1'b1;
    end
  end

  // Read-before-write on a shared address; pipe_q lines data up with the SEND beats.
  always_ff @(posedge clk_i) begin
    if (load_we_i && state_q == StIdle) begin
      mem[load_addr_i] <= load_data_i;
    end
    if (rd_en) begin
      rd_q <= mem[rd_addr];
    end
    pipe_q <= rd_q;
  end

  assign pix_src = pipe_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= StIdle;
      addr_q           <= '0;
      drain_q          <= '0;
      row_q            <= '0;
      col_q            <= '0;
      pix_q            <= '0;
      enable_q         <= 1'b0;
      enable_process_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      fin_q            <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StFetch;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            addr_q  <= (ADDR_W + 1)'(1);
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        StFetch: begin
          addr_q  <= addr_q + 1'b1;
          state_q <= StSend;
        end
        StSend: begin
          enable_q <= 1'b1;
          pix_q    <= pix_src;
          if (addr_q < NumPixA) begin
            addr_q <= addr_q + 1'b1;
          end
          if (row_q == LastRow) begin
            row_q <= '0;
            if (col_q == LastCol) begin
              col_q   <= '0;
              state_q <= StGap;
            end else begin
              col_q <= col_q + 9'd1;
            end
          end else begin
            row_q <= row_q + 9'd1;
          end
        end
        StGap: begin
          enable_q <= 1'b0;
          drain_q  <= '0;
          state_q  <= StProc;
        end
        StProc: begin
          // Fixed-length window: the buffer's finish is sticky and cannot end it early.
          enable_process_q <= 1'b1;
          drain_q          <= drain_q + 1'b1;
          if (drain_q == DrainLast) begin
            fin_q   <= finish_i;
            state_q <= StDone;
          end
        end
        StDone: begin
          enable_process_q <= 1'b0;
          done_q           <= 1'b1;
          busy_q           <= 1'b0;
          if (!(fin_q || finish_i)) begin
            err_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pix_out_o        = pix_q;
  assign enable_o         = enable_q;
  assign enable_process_o = enable_process_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_image_stream_source.sv
// Randomized self-checking bench for image_stream_source (WIDTH=4, DEPTH=3, ADDR_W=4).
module tb_image_stream_source;

  localparam int W = 4;
  localparam int D = 3;
  localparam int N = W * D;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic [7:0]    pix_out;
  logic          enable;
  logic          enable_process;
  logic          finish;
  logic          busy;
  logic          done;
  logic          err;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] mem_m     [16];
  logic [7:0] frame_exp [N];

  always #5 clk = ~clk;

  image_stream_source #(
    .WIDTH (W),
    .DEPTH (D),
    .ADDR_W(AW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .load_we_i       (load_we),
    .load_addr_i     (load_addr),
    .load_data_i     (load_data),
    .pix_out_o       (pix_out),
    .enable_o        (enable),
    .enable_process_o(enable_process),
    .finish_i        (finish),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input bit rnd);
    for (int i = 0; i < N; i++) begin
      load_we   = 1'b1;
      load_addr = AW'(i);
      load_data = rnd ? 8'($urandom) : 8'(i + 16);
      mem_m[i]  = load_data;
      tick();
    end
    load_we = 1'b0;
  endtask

  // Expected frame in stream order: RAM contents, or the row+col ramp.
  task automatic build_exp();
    for (int i = 0; i < N; i++) begin
`ifdef IMG_SRC_PATTERN_EN
      frame_exp[i] = 8'((i % W) + (i / W));
`else
      frame_exp[i] = mem_m[i];
`endif
    end
  endtask

  // Cycle t = period after the t-th edge following the start sample.
  // Beats t=2..13, gap t=14, drain t=15..26, done t=27.
  task automatic run_frame(input logic fin, input bit poke, input int abort_at,
                           input bit ld, input int ld_addr, input logic [7:0] ld_data);
    build_exp();
    if (ld) begin
`ifndef IMG_SRC_PATTERN_EN
      if (ld_addr != 0) frame_exp[ld_addr] = ld_data;
`endif
      mem_m[ld_addr] = ld_data;
      load_we   = 1'b1;
      load_addr = AW'(ld_addr);
      load_data = ld_data;
    end
    finish = fin;
    start  = 1'b1;
    tick();
    start   = 1'b0;
    load_we = 1'b0;
    for (int t = 0; t <= 28; t++) begin
      check($sformatf("busy@%0d", t), busy, t <= 26);
      check($sformatf("enable@%0d", t), enable, t >= 2 && t <= 13);
      if (t >= 2 && t <= 13) check($sformatf("pix@%0d", t), pix_out, frame_exp[t-2]);
      check($sformatf("enproc@%0d", t), enable_process, t >= 15 && t <= 26);
      check($sformatf("done@%0d", t), done, t == 27);
      check($sformatf("err@%0d", t), err, (t >= 27) ? 32'(!fin) : 32'd0);
      if (t == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_enable", enable, 0);
        check("rst_enproc", enable_process, 0);
        check("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      start   = poke && (t == 5);
      load_we = poke && (t == 18);
      if (poke && t == 18) begin
        load_addr = AW'(3);
        load_data = ~mem_m[3];
      end
      tick();
    end
    start   = 1'b0;
    load_we = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b1;
    start     = 1'b0;
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
    finish    = 1'b1;
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    check("reset_pix", pix_out, 0);
    check("reset_enable", enable, 0);
    check("reset_enproc", enable_process, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // i+16 ramp with finish held high from reset: full-length drain, no error.
    load_frame(1'b0);
    run_frame(1'b1, 1'b0, -1, 1'b0, 0, 8'h00);
    // finish never seen: error raised at done, cleared by the next start.
    run_frame(1'b0, 1'b0, -1, 1'b0, 0, 8'h00);
    run_frame(1'b1, 1'b0, -1, 1'b0, 0, 8'h00);
    // Restart/load attempts while busy must be ignored; next frame proves RAM untouched.
    run_frame(1'b1, 1'b1, -1, 1'b0, 0, 8'h00);
    run_frame(1'b1, 1'b0, -1, 1'b0, 0, 8'h00);

    // Reset during the 5th beat, then a fresh frame from address 0.
    load_frame(1'b1);
    run_frame(1'($urandom), 1'b0, 6, 1'b0, 0, 8'h00);
    run_frame(1'($urandom), 1'b0, -1, 1'b0, 0, 8'h00);

    // Load coinciding with start: address 0 reads old data, others read new.
    run_frame(1'b1, 1'b0, -1, 1'b1, 0, 8'($urandom));
    run_frame(1'b1, 1'b0, -1, 1'b1, 7, 8'($urandom));
    run_frame(1'b0, 1'b0, -1, 1'b0, 0, 8'h00);

    for (int k = 0; k < 3; k++) begin
      load_frame(1'b1);
      run_frame(1'($urandom), 1'b0, -1, 1'b1, int'($urandom_range(0, N - 1)), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
